spi_cfg_regfile: RTL

//  Command decoder and double-buffered configuration register file placed directly

---
 rtl/vga_cfg_pkg.sv | 30 +++
 rtl/cfg_shadow_reg.sv | 39 +++
 rtl/spi_cfg_regfile.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_cfg_pkg.sv
// Shared definitions for the SPI configuration path: command byte layout,
// decoder state encoding and the default value of configuration register 0.
package vga_cfg_pkg;

   localparam int          CMD_WRITE_BIT = 7;
   localparam int          CMD_IDX_W     = 2;
   localparam logic [7:0]  CMD_RSVD_MASK = 8'h7C;
   localparam logic [31:0] CFG_RESET     = 32'h80FC_0000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WDATA   = 2'd1,
      ST_RDATA   = 2'd2,
      ST_DISCARD = 2'd3
   } cfg_state_e;

   // Byte k of a word, k = 0 being the most significant (wire order)
   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         2'd3:    b = word[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// One double-buffered configuration register: a shadow written from SPI, an
// active copy driving the pixel path, and a pending bit bridging the two.
module cfg_shadow_reg
   import vga_cfg_pkg::*;
#(
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic        commit,
   output logic [31:0] active,
   output logic        pending
);

   logic [31:0] shadow_r;
   logic [31:0] active_r;
   logic        pending_r;

   // A fresh word takes priority over commit so it waits for the next commit point
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_r  <= RESET_VAL;
         active_r  <= RESET_VAL;
         pending_r <= 1'b0;
      end else if (wr_en) begin
         shadow_r  <= wr_data;
         pending_r <= 1'b1;
      end else if (commit && pending_r) begin
         active_r  <= shadow_r;
         pending_r <= 1'b0;
      end
   end

   assign active  = active_r;
   assign pending = pending_r;

endmodule

// File: rtl/spi_cfg_regfile.sv
// SPI command decoder and double-buffered configuration register file; words
// reach cfg_out only at the commit point so a frame never tears mid-scan.
module spi_cfg_regfile
   import vga_cfg_pkg::*;
#(
   parameter int          NUM_REGS         = 4,
   parameter logic [31:0] RESET_CFG0       = CFG_RESET,
   parameter bit          COMMIT_ON_VBLANK = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  frame_active,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   input  logic                  vblank_start,
   output logic [32*NUM_REGS-1:0] cfg_out,
   output logic [7:0]            tx_byte,
   output logic [NUM_REGS-1:0]   pending,
   output logic                  err_flag
);

   cfg_state_e           state_r;
   cfg_state_e           state_nxt_s;
   logic [1:0]           cnt_r;
   logic [CMD_IDX_W-1:0] idx_r;
   logic [23:0]          asm_r;
   logic                 wr_frame_r;
   logic [7:0]           tx_byte_r;
   logic                 err_r;

   logic                 adv_s;
   logic                 frame_end_s;
   logic                 cmd_write_s;
   logic [CMD_IDX_W-1:0] cmd_idx_s;
   logic                 cmd_bad_s;
   logic                 wr_en_s;
   logic [31:0]          wr_data_s;
   logic                 err_set_s;
   logic                 tx_load_s;
   logic [7:0]           tx_nxt_s;
   logic                 commit_s;
   logic [31:0]          active_s [4];

   assign adv_s       = ena & frame_active & byte_valid;
   assign frame_end_s = ena & ~frame_active;
   assign cmd_write_s = byte_data[CMD_WRITE_BIT];
   assign cmd_idx_s   = byte_data[CMD_IDX_W-1:0];
   assign cmd_bad_s   = (|(byte_data & CMD_RSVD_MASK)) | ({1'b0, cmd_idx_s} >= 3'(NUM_REGS));
   assign wr_data_s   = {asm_r, byte_data};

   // Decoder state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Decoder next state; frame end overrides everything
   always_comb begin
      state_nxt_s = state_r;
      if (frame_end_s) begin
         state_nxt_s = ST_IDLE;
      end else if (adv_s) begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_bad_s) begin
                  state_nxt_s = ST_DISCARD;
               end else if (cmd_write_s) begin
                  state_nxt_s = ST_WDATA;
               end else begin
                  state_nxt_s = ST_RDATA;
               end
            end
            ST_WDATA: begin
               if (cnt_r == 2'd3) begin
                  state_nxt_s = ST_DISCARD;
               end else begin
                  state_nxt_s = ST_WDATA;
               end
            end
            ST_RDATA: begin
               if (cnt_r == 2'd3) begin
                  state_nxt_s = ST_DISCARD;
               end else begin
                  state_nxt_s = ST_RDATA;
               end
            end
            ST_DISCARD: state_nxt_s = ST_DISCARD;
            default:    state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Decoder outputs: shadow write strobe, error set and next read-back byte
   always_comb begin
      wr_en_s   = 1'b0;
      err_set_s = 1'b0;
      tx_load_s = 1'b0;
      tx_nxt_s  = 8'h00;
      if (frame_end_s) begin
         tx_load_s = 1'b1;
         tx_nxt_s  = 8'h00;
      end else if (adv_s) begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_bad_s) begin
                  err_set_s = 1'b1;
               end else if (!cmd_write_s) begin
                  tx_load_s = 1'b1;
                  tx_nxt_s  = word_byte(active_s[cmd_idx_s], 2'd0);
               end else begin
                  tx_load_s = 1'b0;
               end
            end
            ST_WDATA: begin
               if (cnt_r == 2'd3) begin
                  wr_en_s = 1'b1;
               end else begin
                  wr_en_s = 1'b0;
               end
            end
            ST_RDATA: begin
               tx_load_s = 1'b1;
               if (cnt_r == 2'd3) begin
                  tx_nxt_s = 8'h00;
               end else begin
                  tx_nxt_s = word_byte(active_s[idx_r], cnt_r + 2'd1);
               end
            end
            ST_DISCARD: begin
               if (wr_frame_r) begin
                  err_set_s = 1'b1;
               end else begin
                  err_set_s = 1'b0;
               end
            end
            default: begin
               wr_en_s = 1'b0;
            end
         endcase
      end else begin
         tx_load_s = 1'b0;
      end
   end

   // Byte counter, write assembly, read-back byte and sticky error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r      <= 2'd0;
         idx_r      <= '0;
         asm_r      <= 24'h0;
         wr_frame_r <= 1'b0;
         tx_byte_r  <= 8'h00;
         err_r      <= 1'b0;
      end else begin
         err_r <= err_r | err_set_s;
         if (tx_load_s) begin
            tx_byte_r <= tx_nxt_s;
         end
         if (frame_end_s) begin
            cnt_r      <= 2'd0;
            asm_r      <= 24'h0;
            wr_frame_r <= 1'b0;
         end else if (adv_s) begin
            case (state_r)
               ST_IDLE: begin
                  cnt_r <= 2'd0;
                  idx_r <= cmd_idx_s;
               end
               ST_WDATA: begin
                  asm_r <= {asm_r[15:0], byte_data};
                  cnt_r <= cnt_r + 2'd1;
                  if (cnt_r == 2'd3) begin
                     wr_frame_r <= 1'b1;
                  end
               end
               ST_RDATA: cnt_r <= cnt_r + 2'd1;
               default:  cnt_r <= cnt_r;
            endcase
         end
      end
   end

   if (COMMIT_ON_VBLANK) begin : g_commit_vblank
      assign commit_s = ena & vblank_start;
   end else begin : g_commit_now
      assign commit_s = ena;
   end

   for (genvar i = 0; i < 4; i++) begin : g_reg
      if (i < NUM_REGS) begin : g_inst
         cfg_shadow_reg #(
            .RESET_VAL (i == 0 ? RESET_CFG0 : 32'h0000_0000)
         ) u_reg (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en_s && (idx_r == CMD_IDX_W'(i))),
            .wr_data (wr_data_s),
            .commit  (commit_s),
            .active  (active_s[i]),
            .pending (pending[i])
         );
         assign cfg_out[32*i +: 32] = active_s[i];
      end else begin : g_none
         assign active_s[i] = 32'h0000_0000;
      end
   end

   assign tx_byte  = tx_byte_r;
   assign err_flag = err_r;

endmodule
